// File: rtl/mcu_rst_seq_if.sv
// Request/status bundle between the pad top and the reset sequencer.
// The slave side is the sequencer; dbg_state mirrors its FSM for observation.
interface mcu_rst_seq_if #(
    parameter int NUM_DOM = 4
);
    // Requests are plain levels/pulses sampled on CLK (no valid/ready pairing);
    // every status output is a registered value updated on CLK.
    logic               ext_rst_req;
    logic               sys_rst_req;
    logic [NUM_DOM-1:0] sw_rst_req;
    logic               cause_clr;
    logic [NUM_DOM-1:0] dom_rstn;
    logic               rst_busy;
    logic [2:0]         rst_cause;
    logic [1:0]         dbg_state;

    modport master (
        output ext_rst_req, sys_rst_req, sw_rst_req, cause_clr,
        input  dom_rstn, rst_busy, rst_cause, dbg_state
    );

    modport slave (
        input  ext_rst_req, sys_rst_req, sw_rst_req, cause_clr,
        output dom_rstn, rst_busy, rst_cause, dbg_state
    );
endinterface

// File: rtl/mcu_rst_seq.sv
// Reset sequencer: global simultaneous assert, staggered in-order release,
// per-domain software resets and sticky cause. Option macro: RST_SEQ_SYNC_IN_EN.
module mcu_rst_seq #(
    parameter int NUM_DOM     = 4,
    parameter int HOLD_CYC    = 16,
    parameter int STAGGER_CYC = 4,
    parameter int CNT_W       = 8
) (
    input  logic         CLK,
    input  logic         RST,
    mcu_rst_seq_if.slave bus
);

    localparam int IDX_W = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYC);
    localparam logic [CNT_W-1:0] STAG_LAST = CNT_W'(STAGGER_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DOM - 1);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [IDX_W-1:0]   idx_q;
    logic [NUM_DOM-1:0] dom_rstn_q;
    logic               busy_q;
    logic [2:0]         cause_q;
    logic [2:0]         cause_d;
    logic [CNT_W-1:0]   sw_cnt_q [NUM_DOM];

    logic ext_req;
    logic glob_req;
    logic sw_any;

`ifdef RST_SEQ_SYNC_IN_EN
    // Flops come out of reset high so a pad reset still held at RST release is honoured.
    logic ext_meta_q;
    logic ext_sync_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            ext_meta_q <= 1'b1;
            ext_sync_q <= 1'b1;
        end else begin
            ext_meta_q <= bus.ext_rst_req;
            ext_sync_q <= ext_meta_q;
        end
    end

    assign ext_req = ext_sync_q;
`else
    assign ext_req = bus.ext_rst_req;
`endif

    assign glob_req = ext_req | bus.sys_rst_req;

    // Software requests only count in RUN and never for the always-on domain.
    always_comb begin
        sw_any = 1'b0;
        for (int i = 1; i < NUM_DOM; i++) begin
            sw_any = sw_any | bus.sw_rst_req[i];
        end
    end

    // New cause bits override a same-cycle clear.
    always_comb begin
        cause_d = bus.cause_clr ? 3'b000 : cause_q;
        cause_d = cause_d | {sw_any & (state_q == ST_RUN), bus.sys_rst_req, ext_req};
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cause_q <= 3'b000;
        end else begin
            cause_q <= cause_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_ASSERT;
            cnt_q      <= '0;
            idx_q      <= '0;
            dom_rstn_q <= '0;
            busy_q     <= 1'b1;
            for (int i = 0; i < NUM_DOM; i++) begin
                sw_cnt_q[i] <= '0;
            end
        end else if (glob_req) begin
            // A held request parks here with the hold counter pinned at zero.
            state_q    <= ST_ASSERT;
            cnt_q      <= '0;
            idx_q      <= '0;
            dom_rstn_q <= '0;
            busy_q     <= 1'b1;
            for (int i = 0; i < NUM_DOM; i++) begin
                sw_cnt_q[i] <= '0;
            end
        end else begin
            case (state_q)
                ST_ASSERT: begin
                    if (cnt_q == HOLD_LAST) begin
                        cnt_q <= '0;
                        if (NUM_DOM == 1) begin
                            state_q    <= ST_RUN;
                            dom_rstn_q <= '1;
                            busy_q     <= 1'b0;
                        end else begin
                            state_q       <= ST_RELEASE;
                            dom_rstn_q[0] <= 1'b1;
                            idx_q         <= IDX_ONE;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end

                ST_RELEASE: begin
                    if (cnt_q == STAG_LAST) begin
                        cnt_q             <= '0;
                        dom_rstn_q[idx_q] <= 1'b1;
                        if (idx_q == IDX_LAST) begin
                            state_q <= ST_RUN;
                            busy_q  <= 1'b0;
                        end else begin
                            idx_q <= idx_q + IDX_ONE;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end

                ST_RUN: begin
                    // Each domain counts down its own hold; a repeat request reloads it.
                    for (int i = 1; i < NUM_DOM; i++) begin
                        if (bus.sw_rst_req[i]) begin
                            sw_cnt_q[i]   <= HOLD_LOAD;
                            dom_rstn_q[i] <= 1'b0;
                        end else if (sw_cnt_q[i] == CNT_ONE) begin
                            sw_cnt_q[i]   <= '0;
                            dom_rstn_q[i] <= 1'b1;
                        end else if (sw_cnt_q[i] != '0) begin
                            sw_cnt_q[i] <= sw_cnt_q[i] - CNT_ONE;
                        end
                    end
                end

                default: begin
                    state_q    <= ST_ASSERT;
                    cnt_q      <= '0;
                    idx_q      <= '0;
                    dom_rstn_q <= '0;
                    busy_q     <= 1'b1;
                end
            endcase
        end
    end

    assign bus.dom_rstn  = dom_rstn_q;
    assign bus.rst_busy  = busy_q;
    assign bus.rst_cause = cause_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_mcu_rst_seq.sv
// Directed bench for mcu_rst_seq with default parameters (option macro undefined):
// a vector table for the main flow plus hand sequences for abort/re-release.
module tb_mcu_rst_seq;

  localparam int ND = 4;
  localparam int W  = 10;  // {state[1:0], busy, cause[2:0], rstn[3:0]}
  localparam logic [1:0] ST_A = 2'd0;
  localparam logic [1:0] ST_R = 2'd1;
  localparam logic [1:0] ST_U = 2'd2;

  typedef struct {
    string       name;
    logic        ext;
    logic        sys;
    logic [3:0]  sw;
    logic        clr;
    int unsigned edges;
    logic [3:0]  rstn;
    logic        busy;
    logic [2:0]  cause;
    logic [1:0]  st;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [W-1:0] exp_q[$];
  vec_t tbl[$];

  mcu_rst_seq_if #(.NUM_DOM(ND)) bus ();

  mcu_rst_seq #(
    .NUM_DOM(ND),
    .HOLD_CYC(16),
    .STAGGER_CYC(4),
    .CNT_W(8)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks: inputs change and outputs are sampled on the falling edge
  task automatic step(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic set_in(input logic ext, input logic sys, input logic [3:0] sw, input logic clr);
    bus.ext_rst_req = ext;
    bus.sys_rst_req = sys;
    bus.sw_rst_req  = sw;
    bus.cause_clr   = clr;
  endtask

  task automatic do_reset(input int unsigned n);
    rst = 1'b1;
    set_in(1'b0, 1'b0, 4'b0000, 1'b0);
    step(n);
    rst = 1'b0;
  endtask

  // scoreboard
  task automatic check_out(input string nm);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s no expectation queued", nm);
      return;
    end
    e = exp_q.pop_front();
    checks += 4;
    if (bus.dom_rstn !== e[3:0]) begin
      errors++;
      $display("FAIL %s dom_rstn got %b exp %b", nm, bus.dom_rstn, e[3:0]);
    end
    if (bus.rst_cause !== e[6:4]) begin
      errors++;
      $display("FAIL %s rst_cause got %b exp %b", nm, bus.rst_cause, e[6:4]);
    end
    if (bus.rst_busy !== e[7]) begin
      errors++;
      $display("FAIL %s rst_busy got %b exp %b", nm, bus.rst_busy, e[7]);
    end
    if (bus.dbg_state !== e[9:8]) begin
      errors++;
      $display("FAIL %s state got %0d exp %0d", nm, bus.dbg_state, e[9:8]);
    end
  endtask

  task automatic expect_now(input string nm, input logic [3:0] rstn, input logic busy,
                            input logic [2:0] cause, input logic [1:0] st);
    exp_q.push_back({st, busy, cause, rstn});
    check_out(nm);
  endtask

  // inputs are applied for the first edge only, then idle for the remaining edges
  task automatic run_vec(input vec_t v);
    exp_q.push_back({v.st, v.busy, v.cause, v.rstn});
    set_in(v.ext, v.sys, v.sw, v.clr);
    step(1);
    set_in(1'b0, 1'b0, 4'b0000, 1'b0);
    if (v.edges > 1) step(v.edges - 1);
    check_out(v.name);
  endtask

  function automatic vec_t mk(input string nm, input logic ext, input logic sys,
                              input logic [3:0] sw, input logic clr, input int unsigned edges,
                              input logic [3:0] rstn, input logic busy,
                              input logic [2:0] cause, input logic [1:0] st);
    vec_t v;
    v.name = nm; v.ext = ext; v.sys = sys; v.sw = sw; v.clr = clr; v.edges = edges;
    v.rstn = rstn; v.busy = busy; v.cause = cause; v.st = st;
    return v;
  endfunction

  initial begin
    checks = 0;
    errors = 0;

    //                name         ext   sys   sw       clr   edges rstn     busy  cause   st
    tbl.push_back(mk("hold_e15",   1'b0, 1'b0, 4'b0000, 1'b0, 15,   4'b0000, 1'b1, 3'b000, ST_A));
    tbl.push_back(mk("rel0_e16",   1'b0, 1'b0, 4'b0000, 1'b0, 1,    4'b0001, 1'b1, 3'b000, ST_R));
    tbl.push_back(mk("stag_e19",   1'b0, 1'b0, 4'b0000, 1'b0, 3,    4'b0001, 1'b1, 3'b000, ST_R));
    tbl.push_back(mk("rel1_e20",   1'b0, 1'b0, 4'b0000, 1'b0, 1,    4'b0011, 1'b1, 3'b000, ST_R));
    tbl.push_back(mk("rel2_e24",   1'b0, 1'b0, 4'b0000, 1'b0, 4,    4'b0111, 1'b1, 3'b000, ST_R));
    tbl.push_back(mk("pre3_e27",   1'b0, 1'b0, 4'b0000, 1'b0, 3,    4'b0111, 1'b1, 3'b000, ST_R));
    tbl.push_back(mk("rel3_e28",   1'b0, 1'b0, 4'b0000, 1'b0, 1,    4'b1111, 1'b0, 3'b000, ST_U));
    tbl.push_back(mk("sw2_start",  1'b0, 1'b0, 4'b0100, 1'b0, 1,    4'b1011, 1'b0, 3'b100, ST_U));
    tbl.push_back(mk("sw2_h15",    1'b0, 1'b0, 4'b0000, 1'b0, 15,   4'b1011, 1'b0, 3'b100, ST_U));
    tbl.push_back(mk("sw2_end16",  1'b0, 1'b0, 4'b0000, 1'b0, 1,    4'b1111, 1'b0, 3'b100, ST_U));
    tbl.push_back(mk("sw0_ignore", 1'b0, 1'b0, 4'b0001, 1'b0, 1,    4'b1111, 1'b0, 3'b100, ST_U));
    tbl.push_back(mk("clr_run",    1'b0, 1'b0, 4'b0000, 1'b1, 1,    4'b1111, 1'b0, 3'b000, ST_U));
    tbl.push_back(mk("sw1_start",  1'b0, 1'b0, 4'b0010, 1'b0, 1,    4'b1101, 1'b0, 3'b100, ST_U));
    tbl.push_back(mk("sw1_h9",     1'b0, 1'b0, 4'b0000, 1'b0, 9,    4'b1101, 1'b0, 3'b100, ST_U));
    tbl.push_back(mk("sw1_re10",   1'b0, 1'b0, 4'b0010, 1'b0, 1,    4'b1101, 1'b0, 3'b100, ST_U));
    tbl.push_back(mk("sw1_h25",    1'b0, 1'b0, 4'b0000, 1'b0, 15,   4'b1101, 1'b0, 3'b100, ST_U));
    tbl.push_back(mk("sw1_end26",  1'b0, 1'b0, 4'b0000, 1'b0, 1,    4'b1111, 1'b0, 3'b100, ST_U));
    tbl.push_back(mk("mix_ext_sw", 1'b1, 1'b0, 4'b1000, 1'b1, 1,    4'b0000, 1'b1, 3'b101, ST_A));
    tbl.push_back(mk("clr_alone",  1'b0, 1'b0, 4'b0000, 1'b1, 1,    4'b0000, 1'b1, 3'b000, ST_A));
    tbl.push_back(mk("ext_lvl_a",  1'b1, 1'b0, 4'b0000, 1'b0, 1,    4'b0000, 1'b1, 3'b001, ST_A));
    tbl.push_back(mk("ext_lvl_b",  1'b1, 1'b0, 4'b0000, 1'b0, 1,    4'b0000, 1'b1, 3'b001, ST_A));
    tbl.push_back(mk("ext_lvl_c",  1'b1, 1'b0, 4'b0000, 1'b0, 1,    4'b0000, 1'b1, 3'b001, ST_A));
    tbl.push_back(mk("lvl_h15",    1'b0, 1'b0, 4'b0000, 1'b0, 15,   4'b0000, 1'b1, 3'b001, ST_A));
    tbl.push_back(mk("lvl_rel16",  1'b0, 1'b0, 4'b0000, 1'b0, 1,    4'b0001, 1'b1, 3'b001, ST_R));

    // Reset: the last edge with RST high is edge 0.
    do_reset(3);
    expect_now("reset_state", 4'b0000, 1'b1, 3'b000, ST_A);

    foreach (tbl[i]) run_vec(tbl[i]);

    // sys request during RELEASE aborts and restarts the whole sequence
    do_reset(2);
    expect_now("reset2_state", 4'b0000, 1'b1, 3'b000, ST_A);
    step(22);
    expect_now("pre_abort_e22", 4'b0011, 1'b1, 3'b000, ST_R);
    set_in(1'b0, 1'b1, 4'b0000, 1'b0);
    step(1);
    set_in(1'b0, 1'b0, 4'b0000, 1'b0);
    expect_now("abort_e23", 4'b0000, 1'b1, 3'b010, ST_A);
    set_in(1'b0, 1'b0, 4'b1110, 1'b0);
    step(1);
    set_in(1'b0, 1'b0, 4'b0000, 1'b0);
    expect_now("sw_in_assert_e24", 4'b0000, 1'b1, 3'b010, ST_A);
    step(14);
    expect_now("rehold_e38", 4'b0000, 1'b1, 3'b010, ST_A);
    step(1);
    expect_now("rerel0_e39", 4'b0001, 1'b1, 3'b010, ST_R);
    step(11);
    expect_now("rerel2_e50", 4'b0111, 1'b1, 3'b010, ST_R);
    step(1);
    expect_now("rerel3_e51", 4'b1111, 1'b0, 3'b010, ST_U);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
